jit_stream_reduce: RTL and testbench
====================================

Name: jit_stream_reduce

Overview:
- Downstream consumer of the JIT accelerator's 32-bit result stream (mO1 of the compute stage feeds sI1 here).
- Reduces a run of L words with a selectable operation and emits one result word per window of W words, plus a final partial window.
- Output is a single AXI-stream-style master feeding the next writeback stage.
- Run length and mode are configured through the same arg1/arg2/arg3 scalar style as the compute stage.

Parameters:
- DATA_W, 32, stream data width
- LEN_W, 32, run/window counter width; L = {arg1_V, arg2_V}

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- sI1_V_TVALID  in  1  input beat valid
- sI1_V_TREADY  out  1  input beat accepted
- sI1_V_TDATA  in  DATA_W  input data
- mO1_V_TVALID  out  1  result valid
- mO1_V_TREADY  in  1  downstream ready
- mO1_V_TDATA  out  DATA_W  result word, registered
- arg1_V  in  16  run length, high half
- arg2_V  in  16  run length, low half
- arg3_V  in  16  [3:0] op, [7:4] reserved (ignored), [15:8] window W (0 = whole run)
- busy  out  1  high from run start until the final result handshake
- done  out  1  one-cycle pulse on the final result handshake

Behaviour:
- Clock and reset: one clock, ap_clk. Reset is asynchronous and active-low on ap_rst_n.
- Reset values:
  - state IDLE; all counters, accumulator and result register 0
  - sI1_V_TREADY=0, mO1_V_TVALID=0, mO1_V_TDATA=0, busy=0, done=0
  - Reset mid-run discards all partial state immediately; no residue carries into the next run.
- Ops:
  - 1 = sum, wraps mod 2^32
  - 2 = signed max
  - 3 = signed min
  - 4 = count of nonzero words
  - 0 = XOR
  - 5..15 behave as sum
- States, one-hot: IDLE, ACC, EMIT.
- IDLE:
  - sI1_V_TREADY=0.
  - If sI1_V_TVALID=1 and L!=0: latch L, W and op; clear counters; go to ACC. The beat is not consumed in this cycle.
  - If L=0: stay in IDLE; the input is never accepted.
- ACC:
  - sI1_V_TREADY=1. One beat per cycle is accepted on TVALID&&TREADY.
  - First beat of a window: acc = data, or (data!=0) for op 4. Later beats: acc = op(acc, data).
  - run_cnt and win_cnt increment on each accepted beat.
  - If the accepted beat is the run's last (run_cnt==L-1), or closes a window (W!=0 and win_cnt==W-1): load result register = op(acc, data), set last_flag accordingly, go to EMIT.
  - Result is visible on mO1_V_TDATA one cycle after the closing beat.
- EMIT:
  - sI1_V_TREADY=0, mO1_V_TVALID=1. TDATA is held stable until mO1_V_TREADY=1.
  - On handshake with last_flag: go to IDLE, done=1 for that cycle, busy drops next cycle.
  - Otherwise: clear win_cnt, go to ACC.
- mO1_V_TVALID never depends combinationally on mO1_V_TREADY. Each window costs one bubble cycle.
- If W >= L, the behaviour is identical to W=0.
- A run-end that coincides with a window-end produces exactly one result word.
- Arg changes during a run are ignored until the next run start.
- Width rules: the sum wraps to DATA_W bits. The count saturates at 2^32-1, which is unreachable since L < 2^32.

Decomposition:
- Package jit_pkg: op code constants (OP_XOR, OP_SUM, OP_MAX, OP_MIN, OP_CNZ), state encodings (S_IDLE, S_ACC, S_EMIT), arg3 field bit positions.
- Sub-module jit_reduce_alu: purely combinational. Inputs (op, acc, data, first); output next_acc. Shared with future reduction stages.

Test Plan:
1. L=4, op=1, W=0, data 1,2,3,4 -> exactly one mO1 beat of 10; done pulses on its handshake; busy=0 the next cycle.
2. L=5, op=2, W=2, data 3,-7,9,2,-1 -> beats 3, 9, -1 in order; done only on the third.
3. L=3, op=1, W=0, mO1_V_TREADY low for 5 cycles in EMIT -> TVALID held at 1, TDATA stable, sI1_V_TREADY=0 throughout; handshake on the 6th cycle.
4. L=2, op=1, data 0xFFFFFFFF, 0x00000002 -> result 0x00000001. Same data with op=4 -> result 2.
5. L=0, sI1_V_TVALID held high for 20 cycles -> sI1_V_TREADY stays 0, no mO1 beat, busy=0.
6. Assert ap_rst_n low asynchronously after 2 accepted beats of an L=4 sum, then release; run L=2, op=1, data 5,6 -> outputs 0 during reset, then a single beat of 11.

Source files
------------

// File: rtl/jit_pkg.sv
// Shared constants for the JIT result-stream reduction stages.
package jit_pkg;

    localparam logic [3:0] OP_XOR = 4'd0;
    localparam logic [3:0] OP_SUM = 4'd1;
    localparam logic [3:0] OP_MAX = 4'd2;
    localparam logic [3:0] OP_MIN = 4'd3;
    localparam logic [3:0] OP_CNZ = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_ACC  = 3'b010,
        S_EMIT = 3'b100
    } state_t;

    localparam int ARG3_OP_LSB  = 0;
    localparam int ARG3_OP_MSB  = 3;
    localparam int ARG3_WIN_LSB = 8;
    localparam int ARG3_WIN_MSB = 15;

endpackage

// File: rtl/jit_reduce_alu.sv
// Combinational reduction step: folds one data word into the accumulator.
module jit_reduce_alu
    import jit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] data,
    input  logic              first,
    output logic [DATA_W-1:0] next_acc
);

    logic nz;

    // First beat of a window seeds the accumulator; later beats combine with it.
    always_comb begin
        nz       = (data != '0);
        next_acc = acc + data;
        if (first) begin
            next_acc = (op == OP_CNZ) ? {{(DATA_W-1){1'b0}}, nz} : data;
        end else begin
            case (op)
                OP_XOR:  next_acc = acc ^ data;
                OP_MAX:  next_acc = ($signed(acc) > $signed(data)) ? acc : data;
                OP_MIN:  next_acc = ($signed(acc) < $signed(data)) ? acc : data;
                OP_CNZ:  next_acc = (nz && (acc != '1)) ? acc + {{(DATA_W-1){1'b0}}, 1'b1} : acc;
                default: next_acc = acc + data;
            endcase
        end
    end

endmodule

// File: rtl/jit_stream_reduce.sv
// Windowed reduction of the JIT result stream into an AXI-stream master.
//
//  state  | meaning
//  -------+---------------------------------------------------------
//  IDLE   | waiting for input valid with a nonzero run length
//  ACC    | accepting beats, folding them into the accumulator
//  EMIT   | presenting one result word until downstream takes it
module jit_stream_reduce
    import jit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              sI1_V_TVALID,
    output logic              sI1_V_TREADY,
    input  logic [DATA_W-1:0] sI1_V_TDATA,
    output logic              mO1_V_TVALID,
    input  logic              mO1_V_TREADY,
    output logic [DATA_W-1:0] mO1_V_TDATA,
    input  logic [15:0]       arg1_V,
    input  logic [15:0]       arg2_V,
    input  logic [15:0]       arg3_V,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_q, run_cnt, win_cnt;
    logic [7:0]        win_q;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] acc_q, res_q, next_acc;
    logic              last_flag;

    logic [LEN_W-1:0]  arg_len;
    logic              start, beat, run_end, win_end, close_win;
    logic              unused_arg3;

    assign arg_len     = LEN_W'({arg1_V, arg2_V});
    assign unused_arg3 = ^arg3_V[7:4];
    assign start       = (state == S_IDLE) && sI1_V_TVALID && (arg_len != '0);
    assign beat        = (state == S_ACC) && sI1_V_TVALID;
    assign run_end     = (run_cnt == len_q - LEN_W'(1));
    assign win_end     = (win_q != 8'd0) &&
                         (win_cnt == {{(LEN_W-8){1'b0}}, win_q} - LEN_W'(1));
    assign close_win   = beat && (run_end || win_end);
    assign mO1_V_TDATA = res_q;

    jit_reduce_alu #(.DATA_W(DATA_W)) u_alu (
        .op       (op_q),
        .acc      (acc_q),
        .data     (sI1_V_TDATA),
        .first    (win_cnt == '0),
        .next_acc (next_acc)
    );

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Next-state and handshake outputs, all decoded from state.
    always_comb begin
        state_nxt    = state;
        sI1_V_TREADY = 1'b0;
        mO1_V_TVALID = 1'b0;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_ACC;
            S_ACC: begin
                sI1_V_TREADY = 1'b1;
                if (close_win) state_nxt = S_EMIT;
            end
            S_EMIT: begin
                mO1_V_TVALID = 1'b1;
                if (mO1_V_TREADY) begin
                    done      = last_flag;
                    state_nxt = last_flag ? S_IDLE : S_ACC;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Run configuration, counters, accumulator and result register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            len_q     <= '0;
            win_q     <= '0;
            op_q      <= '0;
            run_cnt   <= '0;
            win_cnt   <= '0;
            acc_q     <= '0;
            res_q     <= '0;
            last_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    len_q     <= arg_len;
                    win_q     <= arg3_V[ARG3_WIN_MSB:ARG3_WIN_LSB];
                    op_q      <= arg3_V[ARG3_OP_MSB:ARG3_OP_LSB];
                    run_cnt   <= '0;
                    win_cnt   <= '0;
                    acc_q     <= '0;
                    last_flag <= 1'b0;
                end
                S_ACC: if (beat) begin
                    acc_q   <= next_acc;
                    run_cnt <= run_cnt + LEN_W'(1);
                    win_cnt <= win_cnt + LEN_W'(1);
                    if (close_win) begin
                        res_q     <= next_acc;
                        last_flag <= run_end;
                    end
                end
                S_EMIT: if (mO1_V_TREADY && !last_flag) win_cnt <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jit_stream_reduce.sv
// Directed bench for jit_stream_reduce: vector table plus corner sequences.
module tb_jit_stream_reduce;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        sI1_V_TVALID, sI1_V_TREADY;
    logic [31:0] sI1_V_TDATA;
    logic        mO1_V_TVALID, mO1_V_TREADY;
    logic [31:0] mO1_V_TDATA;
    logic [15:0] arg1_V, arg2_V, arg3_V;
    logic        busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ap_clk = ~ap_clk;

    jit_stream_reduce dut (
        .ap_clk       (ap_clk),
        .ap_rst_n     (ap_rst_n),
        .sI1_V_TVALID (sI1_V_TVALID),
        .sI1_V_TREADY (sI1_V_TREADY),
        .sI1_V_TDATA  (sI1_V_TDATA),
        .mO1_V_TVALID (mO1_V_TVALID),
        .mO1_V_TREADY (mO1_V_TREADY),
        .mO1_V_TDATA  (mO1_V_TDATA),
        .arg1_V       (arg1_V),
        .arg2_V       (arg2_V),
        .arg3_V       (arg3_V),
        .busy         (busy),
        .done         (done)
    );

    typedef struct {
        string            name;
        logic [31:0]      len;
        logic [3:0]       op;
        logic [7:0]       win;
        int               nd;
        logic [5:0][31:0] data;
        int               ne;
        logic [3:0][31:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", what, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] len, input logic [3:0] op,
                                input logic [7:0] win, input int nd,
                                input logic [31:0] d0, d1, d2, d3, d4, d5,
                                input int ne, input logic [31:0] e0, e1, e2, e3);
        vec_t v;
        v.name = name; v.len = len; v.op = op; v.win = win; v.nd = nd; v.ne = ne;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
        v.data[3] = d3; v.data[4] = d4; v.data[5] = d5;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    // Feeds a run with an always-ready sink; args are scrambled after the
    // first accepted beat to confirm they are latched at run start.
    task automatic run_vec(input vec_t v);
        int idx, got, ndone;
        bit fin;
        idx = 0; got = 0; ndone = 0; fin = 0;
        arg1_V = v.len[31:16];
        arg2_V = v.len[15:0];
        arg3_V = {v.win, 4'h0, v.op};
        for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
            @(negedge ap_clk);
            sI1_V_TVALID = (idx < v.nd);
            sI1_V_TDATA  = 32'h0;
            if (idx < v.nd) sI1_V_TDATA = v.data[idx];
            mO1_V_TREADY = 1'b1;
            #1;
            if (done) ndone++;
            if (mO1_V_TVALID && mO1_V_TREADY) begin
                if (got < v.ne) check($sformatf("%s.beat%0d", v.name, got), mO1_V_TDATA, v.exp[got]);
                check($sformatf("%s.done%0d", v.name, got), {31'd0, done}, {31'd0, got == v.ne - 1});
                if (done) fin = 1;
                got++;
            end
            if (sI1_V_TVALID && sI1_V_TREADY) begin
                idx++;
                if (idx == 1) begin
                    arg1_V = 16'hFFFF; arg2_V = 16'hFFFF; arg3_V = 16'hFFFF;
                end
            end
        end
        sI1_V_TVALID = 1'b0;
        check({v.name, ".finished"}, {31'd0, fin}, 32'd1);
        check({v.name, ".nbeats"}, got, v.ne);
        check({v.name, ".ndone"}, ndone, 32'd1);
        @(negedge ap_clk); #1;
        check({v.name, ".busy_after"}, {31'd0, busy}, 32'd0);
        check({v.name, ".valid_after"}, {31'd0, mO1_V_TVALID}, 32'd0);
    endtask

    initial begin
        int idx;
        bit seen;
        ap_rst_n = 1'b0;
        sI1_V_TVALID = 1'b0; sI1_V_TDATA = 32'h0; mO1_V_TREADY = 1'b0;
        arg1_V = 16'h0; arg2_V = 16'h0; arg3_V = 16'h0;

        vecs[0] = mk("sum4",     4, 4'd1, 8'd0, 4, 1, 2, 3, 4, 0, 0, 1, 10, 0, 0, 0);
        vecs[1] = mk("max_w2",   5, 4'd2, 8'd2, 5, 3, 32'hFFFFFFF9, 9, 2, 32'hFFFFFFFF, 0,
                     3, 3, 9, 32'hFFFFFFFF, 0);
        vecs[2] = mk("sum_wrap", 2, 4'd1, 8'd0, 2, 32'hFFFFFFFF, 2, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        vecs[3] = mk("cnz",      2, 4'd4, 8'd0, 2, 32'hFFFFFFFF, 2, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        vecs[4] = mk("xor3",     3, 4'd0, 8'd0, 3, 5, 3, 32'hF0, 0, 0, 0, 1, 32'hF6, 0, 0, 0);
        vecs[5] = mk("min_wgel", 4, 4'd3, 8'd4, 4, 5, 32'hFFFFFFFE, 7, 32'hFFFFFFF7, 0, 0,
                     1, 32'hFFFFFFF7, 0, 0, 0);
        vecs[6] = mk("op7_w1",   3, 4'd7, 8'd1, 3, 1, 2, 3, 0, 0, 0, 3, 1, 2, 3, 0);
        vecs[7] = mk("coincide", 4, 4'd1, 8'd2, 4, 1, 2, 3, 4, 0, 0, 2, 3, 7, 0, 0);
        vecs[8] = mk("cnz_zero", 4, 4'd4, 8'd0, 4, 0, 5, 0, 7, 0, 0, 1, 2, 0, 0, 0);

        // Reset values
        @(negedge ap_clk); #1;
        check("rst.in_ready", {31'd0, sI1_V_TREADY}, 32'd0);
        check("rst.out_valid", {31'd0, mO1_V_TVALID}, 32'd0);
        check("rst.out_data", mO1_V_TDATA, 32'd0);
        check("rst.busy", {31'd0, busy}, 32'd0);
        check("rst.done", {31'd0, done}, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Backpressure: sink stalls five EMIT cycles, takes on the sixth
        arg1_V = 16'h0; arg2_V = 16'd3; arg3_V = 16'h0001;
        idx = 0; seen = 0;
        for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
            @(negedge ap_clk);
            sI1_V_TVALID = (idx < 3);
            sI1_V_TDATA  = 32'(idx + 1);
            mO1_V_TREADY = 1'b0;
            #1;
            if (mO1_V_TVALID) seen = 1;
            else if (sI1_V_TVALID && sI1_V_TREADY) idx++;
        end
        sI1_V_TVALID = 1'b0;
        check("bp.reached_emit", {31'd0, seen}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge ap_clk); #1; end
            check($sformatf("bp.valid%0d", k), {31'd0, mO1_V_TVALID}, 32'd1);
            check($sformatf("bp.data%0d", k), mO1_V_TDATA, 32'd6);
            check($sformatf("bp.in_ready%0d", k), {31'd0, sI1_V_TREADY}, 32'd0);
            check($sformatf("bp.done%0d", k), {31'd0, done}, 32'd0);
        end
        @(negedge ap_clk);
        mO1_V_TREADY = 1'b1;
        #1;
        check("bp.valid6", {31'd0, mO1_V_TVALID}, 32'd1);
        check("bp.data6", mO1_V_TDATA, 32'd6);
        check("bp.done6", {31'd0, done}, 32'd1);
        @(negedge ap_clk); #1;
        check("bp.busy_after", {31'd0, busy}, 32'd0);

        // Zero run length: input never accepted
        arg1_V = 16'h0; arg2_V = 16'h0; arg3_V = 16'h0001;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge ap_clk);
            sI1_V_TVALID = 1'b1;
            sI1_V_TDATA  = 32'h55;
            #1;
            check($sformatf("l0.in_ready%0d", cyc), {31'd0, sI1_V_TREADY}, 32'd0);
            check($sformatf("l0.out_valid%0d", cyc), {31'd0, mO1_V_TVALID}, 32'd0);
            check($sformatf("l0.busy%0d", cyc), {31'd0, busy}, 32'd0);
        end
        sI1_V_TVALID = 1'b0;

        // Asynchronous reset after two accepted beats of an L=4 sum
        arg1_V = 16'h0; arg2_V = 16'd4; arg3_V = 16'h0001;
        idx = 0;
        for (int cyc = 0; cyc < 50 && idx < 2; cyc++) begin
            @(negedge ap_clk);
            sI1_V_TVALID = 1'b1;
            sI1_V_TDATA  = 32'd100;
            mO1_V_TREADY = 1'b1;
            #1;
            if (sI1_V_TVALID && sI1_V_TREADY) idx++;
        end
        check("ar.two_beats", idx, 32'd2);
        #2;
        ap_rst_n = 1'b0;
        sI1_V_TVALID = 1'b0;
        #1;
        check("ar.in_ready", {31'd0, sI1_V_TREADY}, 32'd0);
        check("ar.out_valid", {31'd0, mO1_V_TVALID}, 32'd0);
        check("ar.out_data", mO1_V_TDATA, 32'd0);
        check("ar.busy", {31'd0, busy}, 32'd0);
        check("ar.done", {31'd0, done}, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        run_vec(mk("after_rst", 2, 4'd1, 8'd0, 2, 5, 6, 0, 0, 0, 0, 1, 11, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
